// File: rtl/conv_pkg.sv
// Shared types and size helpers for the 1-D convolution stream engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } state_t;

  function automatic int calc_l(input int n, input int m);
    return n + m - 1;
  endfunction

  function automatic int calc_acc_w(input int dw, input int n, input int m);
    return 2 * dw + $clog2((n < m) ? n : m);
  endfunction

  function automatic int calc_idx_w(input int n, input int m);
    int l;
    l = n + m - 1;
    return ($clog2(l) > 1) ? $clog2(l) : 1;
  endfunction

endpackage

// File: rtl/conv_tap_mac.sv
// Combinational y[k] of a full convolution: M masked multipliers and an adder tree.
module conv_tap_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int N = 4,
  parameter int M = 4,
  localparam int ACC_W = calc_acc_w(DATA_W, N, M),
  localparam int IDX_W = calc_idx_w(N, M)
) (
  input  logic [N*DATA_W-1:0] x,
  input  logic [M*DATA_W-1:0] h,
  input  logic                sgn,
  input  logic [IDX_W-1:0]    k,
  output logic [ACC_W-1:0]    y
);

  localparam int PW = 2 * DATA_W;

  logic [DATA_W-1:0] xs;
  logic [DATA_W-1:0] hs;
  logic [PW-1:0]     xe;
  logic [PW-1:0]     he;
  logic [PW-1:0]     p;
  logic [ACC_W-1:0]  pe;

  always_comb begin
    y  = '0;
    xs = '0;
    hs = '0;
    xe = '0;
    he = '0;
    p  = '0;
    pe = '0;
    for (int j = 0; j < M; j++) begin
      // Pick x[k-j]; stays zero when k-j falls outside the input (padding).
      xs = '0;
      for (int i = 0; i < N; i++) begin
        if (i + j == int'(k)) xs = x[i*DATA_W +: DATA_W];
      end
      hs = h[j*DATA_W +: DATA_W];
      xe = sgn ? PW'($signed(xs)) : PW'(xs);
      he = sgn ? PW'($signed(hs)) : PW'(hs);
      p  = xe * he;
      pe = sgn ? ACC_W'($signed(p)) : ACC_W'(p);
      y  = y + pe;
    end
  end

endmodule

// File: rtl/conv1d_stream_unit.sv
// Sequential full 1-D convolution: latch operands, stream y[0..L-1] with backpressure.
module conv1d_stream_unit
  import conv_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int N = 4,
  parameter int M = 4,
  localparam int L = calc_l(N, M),
  localparam int ACC_W = calc_acc_w(DATA_W, N, M),
  localparam int IDX_W = calc_idx_w(N, M)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_signed,
  input  logic [N*DATA_W-1:0] in_x,
  input  logic [M*DATA_W-1:0] in_h,
  input  logic                clear,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic                busy
);

  state_t state;
  state_t nxt;

  logic [N*DATA_W-1:0] xr;
  logic [M*DATA_W-1:0] hr;
  logic                sr;
  logic [IDX_W-1:0]    k;
  logic [IDX_W-1:0]    kq;
  logic [ACC_W-1:0]    yk;
  logic                last_k;
  logic                hs;

  assign last_k   = (k == IDX_W'(L - 1));
  assign hs       = out_valid & out_ready;
  assign kq       = (state == LOAD) ? '0 : k + 1'b1;
  assign out_idx  = k;
  assign out_last = out_valid & last_k;
  assign busy     = (state != IDLE);

  conv_tap_mac #(
    .DATA_W(DATA_W),
    .N(N),
    .M(M)
  ) u_mac (
    .x(xr),
    .h(hr),
    .sgn(sr),
    .k(kq),
    .y(yk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = LOAD;
      end
      LOAD:   nxt = STREAM;
      STREAM: if (hs && last_k) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (clear) nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr        <= '0;
      hr        <= '0;
      sr        <= 1'b0;
      k         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      xr        <= '0;
      hr        <= '0;
      sr        <= 1'b0;
      k         <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            xr <= in_x;
            hr <= in_h;
            sr <= in_signed;
          end
        end
        LOAD: begin
          out_data  <= yk;
          k         <= '0;
          out_valid <= 1'b1;
        end
        STREAM: begin
          if (hs) begin
            if (last_k) begin
              out_valid <= 1'b0;
            end else begin
              out_data <= yk;
              k        <= k + 1'b1;
            end
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_stream_unit.sv
// Directed bench for conv1d_stream_unit with hand-computed convolution results.
module tb_conv1d_stream_unit;

  localparam int DW = 4;
  localparam int N  = 4;
  localparam int M  = 4;
  localparam int L  = 7;
  localparam int AW = 10;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_signed = 1'b0;
  logic [N*DW-1:0] in_x = '0;
  logic [M*DW-1:0] in_h = '0;
  logic           clear = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [AW-1:0]  out_data;
  logic [IW-1:0]  out_idx;
  logic           out_last;
  logic           busy;

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] got_d [L];
  logic [IW-1:0] got_i [L];
  logic          got_l [L];
  int            n_got;
  int            first_cyc;
  bit            tmo;

  always #5 clk = ~clk;

  conv1d_stream_unit #(
    .DATA_W(DW),
    .N(N),
    .M(M)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_signed(in_signed),
    .in_x(in_x),
    .in_h(in_h),
    .clear(clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_idx(out_idx),
    .out_last(out_last),
    .busy(busy)
  );

  task automatic start_op(input logic s, input logic [15:0] x, input logic [15:0] h);
    in_signed = s;
    in_x      = x;
    in_h      = h;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect();
    n_got     = 0;
    first_cyc = -1;
    tmo       = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && n_got < L; c++) begin
      @(negedge clk);
      if (out_valid && first_cyc < 0) first_cyc = c;
      if (out_valid && out_ready) begin
        got_d[n_got] = out_data;
        got_i[n_got] = out_idx;
        got_l[n_got] = out_last;
        n_got++;
      end
      @(posedge clk);
      #1;
    end
    if (n_got < L) tmo = 1;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0 ||
        out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: v=%b d=%h i=%0d l=%b busy=%b rdy=%b want 0 0 0 0 0 1",
               out_valid, out_data, out_idx, out_last, busy, in_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int ex [L] = '{1, 3, 6, 10, 9, 7, 4};
    start_op(1'b0, 16'h4321, 16'h1111);
    collect();
    tests++;
    if (tmo || first_cyc !== 1) begin
      fails++;
      $display("FAIL unsigned_latency: got n=%0d first=%0d want n=%0d first=1",
               n_got, first_cyc, L);
    end
    for (int i = 0; i < n_got; i++) begin
      tests++;
      if (got_d[i] !== AW'(ex[i]) || got_i[i] !== IW'(i) || got_l[i] !== (i == L - 1)) begin
        fails++;
        $display("FAIL unsigned[%0d]: got d=%h i=%0d l=%b want d=%h i=%0d l=%b",
                 i, got_d[i], got_i[i], got_l[i], AW'(ex[i]), i, (i == L - 1));
      end
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL unsigned_done: got rdy=%b busy=%b v=%b want 1 0 0",
               in_ready, busy, out_valid);
    end
  endtask

  task automatic test_unsigned_max();
    int ex [L] = '{225, 450, 675, 900, 675, 450, 225};
    start_op(1'b0, 16'hFFFF, 16'hFFFF);
    collect();
    tests++;
    if (tmo) begin
      fails++;
      $display("FAIL umax_count: got %0d want %0d", n_got, L);
    end
    for (int i = 0; i < n_got; i++) begin
      tests++;
      if (got_d[i] !== AW'(ex[i]) || got_i[i] !== IW'(i)) begin
        fails++;
        $display("FAIL umax[%0d]: got d=%h i=%0d want d=%h", i, got_d[i], got_i[i], AW'(ex[i]));
      end
    end
  endtask

  task automatic test_signed_min();
    int ex [L] = '{64, 128, 192, 256, 192, 128, 64};
    start_op(1'b1, 16'h8888, 16'h8888);
    collect();
    tests++;
    if (tmo) begin
      fails++;
      $display("FAIL smin_count: got %0d want %0d", n_got, L);
    end
    for (int i = 0; i < n_got; i++) begin
      tests++;
      if (got_d[i] !== AW'(ex[i])) begin
        fails++;
        $display("FAIL smin[%0d]: got %h want %h", i, got_d[i], AW'(ex[i]));
      end
    end
  endtask

  task automatic test_signed_mixed();
    int ex [L] = '{-1, 2, -3, 4, 0, 0, 0};
    start_op(1'b1, 16'h4D2F, 16'h0001);
    collect();
    tests++;
    if (tmo) begin
      fails++;
      $display("FAIL smix_count: got %0d want %0d", n_got, L);
    end
    for (int i = 0; i < n_got; i++) begin
      tests++;
      if (got_d[i] !== AW'(ex[i]) || got_l[i] !== (i == L - 1)) begin
        fails++;
        $display("FAIL smix[%0d]: got d=%h l=%b want d=%h", i, got_d[i], got_l[i], AW'(ex[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    int ex [L] = '{4, 11, 20, 30, 20, 11, 4};
    logic          stalled;
    logic [AW-1:0] pd;
    logic [IW-1:0] pi;
    logic          pl;
    stalled = 1'b0;
    pd = '0;
    pi = '0;
    pl = 1'b0;
    n_got = 0;
    start_op(1'b0, 16'h4321, 16'h1234);
    in_valid  = 1'b1;
    in_x      = 16'hFFFF;
    in_h      = 16'hFFFF;
    out_ready = 1'b0;
    for (int c = 0; c < 300 && n_got < L; c++) begin
      @(negedge clk);
      tests++;
      if (busy && in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_in_ready: got %b want 0 at cycle %0d", in_ready, c);
      end
      if (stalled) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== pd || out_idx !== pi || out_last !== pl) begin
          fails++;
          $display("FAIL bp_stable: got v=%b d=%h i=%0d l=%b want 1 %h %0d %b",
                   out_valid, out_data, out_idx, out_last, pd, pi, pl);
        end
      end
      stalled = out_valid && !out_ready;
      pd = out_data;
      pi = out_idx;
      pl = out_last;
      if (out_valid && out_ready) begin
        got_d[n_got] = out_data;
        got_i[n_got] = out_idx;
        got_l[n_got] = out_last;
        n_got++;
      end
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (n_got != L) begin
      fails++;
      $display("FAIL bp_count: got %0d want %0d", n_got, L);
    end
    for (int i = 0; i < n_got; i++) begin
      tests++;
      if (got_d[i] !== AW'(ex[i]) || got_i[i] !== IW'(i) || got_l[i] !== (i == L - 1)) begin
        fails++;
        $display("FAIL bp[%0d]: got d=%h i=%0d l=%b want d=%h i=%0d", i, got_d[i], got_i[i],
                 got_l[i], AW'(ex[i]), i);
      end
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_idle: got busy=%b rdy=%b want 0 1", busy, in_ready);
    end
  endtask

  task automatic test_clear();
    int  ex [L] = '{225, 450, 675, 900, 675, 450, 225};
    bit  hit;
    hit = 0;
    out_ready = 1'b1;
    start_op(1'b0, 16'h4321, 16'h1111);
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (out_valid && out_idx == 3) begin
        hit   = 1;
        clear = 1'b1;
      end
      @(posedge clk);
      #1 clear = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (!hit || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL clear: got hit=%0d v=%b rdy=%b busy=%b want 1 0 1 0",
               hit, out_valid, in_ready, busy);
    end
    in_valid = 1'b1;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL clear_accept: got busy=%b want 0", busy);
    end
    start_op(1'b0, 16'hFFFF, 16'hFFFF);
    collect();
    tests++;
    if (tmo) begin
      fails++;
      $display("FAIL clear_after_count: got %0d want %0d", n_got, L);
    end
    for (int i = 0; i < n_got; i++) begin
      tests++;
      if (got_d[i] !== AW'(ex[i]) || got_i[i] !== IW'(i)) begin
        fails++;
        $display("FAIL clear_after[%0d]: got d=%h i=%0d want %h", i, got_d[i], got_i[i],
                 AW'(ex[i]));
      end
    end
  endtask

  task automatic test_async_reset();
    int ex [L] = '{-1, 2, -3, 4, 0, 0, 0};
    bit hit;
    hit = 0;
    out_ready = 1'b1;
    start_op(1'b0, 16'h4321, 16'h1111);
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (out_valid && out_idx == 2) hit = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (!hit || out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0 ||
        out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_rst: got hit=%0d v=%b d=%h i=%0d l=%b busy=%b rdy=%b",
               hit, out_valid, out_data, out_idx, out_last, busy, in_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    start_op(1'b1, 16'h4D2F, 16'h0001);
    collect();
    tests++;
    if (tmo || first_cyc !== 1) begin
      fails++;
      $display("FAIL rst_after_count: got n=%0d first=%0d want %0d 1", n_got, first_cyc, L);
    end
    for (int i = 0; i < n_got; i++) begin
      tests++;
      if (got_d[i] !== AW'(ex[i]) || got_i[i] !== IW'(i)) begin
        fails++;
        $display("FAIL rst_after[%0d]: got d=%h i=%0d want %h", i, got_d[i], got_i[i],
                 AW'(ex[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_unsigned_max();
    test_signed_min();
    test_signed_mixed();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
